// File: rtl/tjpu_pkg.sv
// Shared TJPU feature-path definitions: padding FSM states, default field
// widths and padded-dimension helper.
package tjpu_pkg;

  localparam int unsigned DEF_DIM_BITS = 11;
  localparam int unsigned DEF_PAD_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    LEFT,
    BODY,
    RIGHT,
    BOTTOM,
    FIN
  } pad_state_t;

  // dim + 2*pad, one bit wider than dim so it can never overflow.
  function automatic logic [16:0] padded_dim(input logic [15:0] dim, input logic [3:0] pad);
    return {1'b0, dim} + {12'b0, pad, 1'b0};
  endfunction

endpackage

// File: rtl/padding_gen_if.sv
// Stream-in / FIFO-out bundle of the padding generator.
interface padding_gen_if #(
  parameter int unsigned WIDTH = 256
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_wr_en;
  logic             fifo_s_ready;

  // padding_gen side
  modport slave (
    input  s_data, s_valid, fifo_s_ready,
    output s_ready, fifo_din, fifo_wr_en
  );

  // producer / FIFO side
  modport master (
    output s_data, s_valid, fifo_s_ready,
    input  s_ready, fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/pad_counter.sv
// 2-D column/row sweep counter with clear, enable and terminal-value flags.
module pad_counter #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] col_last,
  input  logic [W-1:0] row_last,
  output logic [W-1:0] col,
  output logic [W-1:0] row,
  output logic         col_wrap,
  output logic         row_wrap
);

  // Terminal flags: the next advance wraps the column (and the row).
  always_comb begin
    col_wrap = (col == col_last);
    row_wrap = (row == row_last);
  end

  // Column advances per enable; row advances when the column wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/padding_gen.sv
// Wraps an unpadded row-major feature map with P zero words on every side
// and writes the padded map into the padding FIFO, throttled by its S_Ready.
module padding_gen
  import tjpu_pkg::*;
#(
  parameter int unsigned WIDTH    = 256,
  parameter int unsigned DIM_BITS = DEF_DIM_BITS,
  parameter int unsigned PAD_BITS = DEF_PAD_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM_BITS-1:0] cfg_cols,
  input  logic [DIM_BITS-1:0] cfg_rows,
  input  logic [PAD_BITS-1:0] cfg_pad,
  padding_gen_if.slave        bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CW = DIM_BITS + 1;

  pad_state_t    state_q, state_d, region;
  logic [CW-1:0] cols_q, rows_q, pad_q, w_q, h_q;
  logic          zero_q;
  logic          cfg_zero, accept_start;
  logic          pad_slot, fire;
  logic [CW-1:0] col_cnt, row_cnt, col_last, row_last;
  logic [CW-1:0] nxt_col, nxt_row;
  logic          col_wrap, row_wrap;

  // Start handling, emit decision and handshake outputs.
  always_comb begin
    cfg_zero     = (cfg_cols == '0) || (cfg_rows == '0);
    accept_start = (state_q == IDLE) && start;
    pad_slot     = (state_q == TOP) || (state_q == LEFT) ||
                   (state_q == RIGHT) || (state_q == BOTTOM);
    bus.s_ready  = (state_q == BODY) && bus.fifo_s_ready;
    fire         = !zero_q && bus.fifo_s_ready &&
                   (pad_slot || ((state_q == BODY) && bus.s_valid));
    col_last     = w_q - 1'b1;
    row_last     = h_q - 1'b1;
    busy         = (state_q != IDLE);
    done         = (state_q == FIN);
  end

  // Frame configuration, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q <= '0;
      rows_q <= '0;
      pad_q  <= '0;
      w_q    <= '0;
      h_q    <= '0;
      zero_q <= 1'b0;
    end else if (accept_start) begin
      cols_q <= CW'(cfg_cols);
      rows_q <= CW'(cfg_rows);
      pad_q  <= CW'(cfg_pad);
      w_q    <= CW'(padded_dim(16'(cfg_cols), 4'(cfg_pad)));
      h_q    <= CW'(padded_dim(16'(cfg_rows), 4'(cfg_pad)));
      zero_q <= cfg_zero;
    end
  end

  pad_counter #(
    .W(CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept_start),
    .en       (fire),
    .col_last (col_last),
    .row_last (row_last),
    .col      (col_cnt),
    .row      (row_cnt),
    .col_wrap (col_wrap),
    .row_wrap (row_wrap)
  );

  // Region of the padded position the sweep moves to after this emit.
  // Deriving the next state from that position realises all the per-state
  // emit counts (P*W, P, cols, P) without separate per-state counters.
  always_comb begin
    nxt_col = col_wrap ? '0 : col_cnt + 1'b1;
    nxt_row = col_wrap ? row_cnt + 1'b1 : row_cnt;
    if (nxt_row < pad_q)                  region = TOP;
    else if (nxt_row >= pad_q + rows_q)   region = BOTTOM;
    else if (nxt_col < pad_q)             region = LEFT;
    else if (nxt_col < pad_q + cols_q)    region = BODY;
    else                                  region = RIGHT;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Empty maps pass through one non-emitting state so done lands
          // two cycles after start.
          if (cfg_zero)             state_d = LEFT;
          else if (cfg_pad != '0)   state_d = TOP;
          else                      state_d = BODY;
        end
      end
      FIN:     state_d = IDLE;
      default: begin
        if (zero_q)    state_d = FIN;
        else if (fire) state_d = (col_wrap && row_wrap) ? FIN : region;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FIFO write register: one-cycle latency, data held between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_din   <= '0;
    end else begin
      bus.fifo_wr_en <= fire;
      if (fire) bus.fifo_din <= (state_q == BODY) ? bus.s_data : '0;
    end
  end

endmodule

// File: tb/tb_padding_gen.sv
// Self-checking bench for padding_gen: table of directed frames, random
// frames, and a queue-based reference of the padded map.
module tb_padding_gen;

  localparam int unsigned WIDTH  = 256;
  localparam int unsigned DB     = 11;
  localparam int unsigned PB     = 2;
  localparam int          BUDGET = 1000;
  localparam int          NV     = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DB-1:0] cfg_cols, cfg_rows;
  logic [PB-1:0] cfg_pad;
  logic          busy, done;

  padding_gen_if #(.WIDTH(WIDTH)) bus ();

  padding_gen #(
    .WIDTH    (WIDTH),
    .DIM_BITS (DB),
    .PAD_BITS (PB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_cols (cfg_cols),
    .cfg_rows (cfg_rows),
    .cfg_pad  (cfg_pad),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cols;
    int rows;
    int pad;
    int vmode;        // 0 always valid, 1 every other cycle, 2 random
    int rmode;        // 0 always ready, 1 drop iters 12..16, 2 random
    int restart_iter; // iteration of an ignored start re-pulse, -1 none
    int rst_write;    // assert rst when this write is seen, -1 none
    int exp_writes;   // -1: take from model only
    int exp_first;    // iteration of first write, -1 unchecked
    int exp_done;     // iteration of done, -1 unchecked
  } vec_t;

  vec_t  vecs  [NV];
  string names [NV];

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] src[$];
  logic [WIDTH-1:0] got[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int unsigned i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference: the padded map read in raster order.
  task automatic build_model(input int cols, input int rows, input int pad);
    exp_q.delete();
    if (cols > 0 && rows > 0) begin
      for (int r = 0; r < rows + 2 * pad; r++)
        for (int c = 0; c < cols + 2 * pad; c++)
          if (r >= pad && r < pad + rows && c >= pad && c < pad + cols)
            exp_q.push_back(src[(r - pad) * cols + (c - pad)]);
          else
            exp_q.push_back('0);
    end
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int               idx, first_w, done_it, total_in, nbad;
    logic             last_ready, wr_at_done;
    logic [WIDTH-1:0] last_din;
    src.delete();
    got.delete();
    total_in = v.cols * v.rows;
    for (int k = 0; k < total_in; k++) src.push_back(rand_word());
    build_model(v.cols, v.rows, v.pad);
    idx = 0; first_w = -1; done_it = -1; last_ready = 1'b1; wr_at_done = 1'b0;
    last_din = bus.fifo_din;
    for (int it = 0; it < BUDGET; it++) begin
      @(negedge clk);
      if (it > 0 && !last_ready) chk({nm, "/stall_no_write"}, bus.fifo_wr_en, 0);
      if (bus.fifo_wr_en) begin
        got.push_back(bus.fifo_din);
        if (first_w < 0) first_w = it;
      end else if (it > 0) begin
        chk({nm, "/din_hold"}, bus.fifo_din == last_din, 1);
      end
      last_din = bus.fifo_din;
      if (it >= 1) chk({nm, "/busy"}, busy, 1);
      if (v.rst_write > 0 && got.size() == v.rst_write) begin
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk({nm, "/rst_wr_en"}, bus.fifo_wr_en, 0);
        chk({nm, "/rst_din_zero"}, bus.fifo_din == '0, 1);
        chk({nm, "/rst_busy"}, busy, 0);
        chk({nm, "/rst_done"}, done, 0);
        rst = 1'b0; bus.s_valid = 1'b1; bus.fifo_s_ready = 1'b1;
        repeat (10) begin
          @(negedge clk);
          chk({nm, "/post_rst_wr_en"}, bus.fifo_wr_en, 0);
          chk({nm, "/post_rst_done"}, done, 0);
        end
        return;
      end
      if (done) begin
        done_it = it;
        wr_at_done = bus.fifo_wr_en;
        break;
      end
      // drive the next cycle
      start = (it == 0) || (it == v.restart_iter);
      if (it == 0) begin
        cfg_cols = DB'(v.cols); cfg_rows = DB'(v.rows); cfg_pad = PB'(v.pad);
      end else if (it == v.restart_iter) begin
        cfg_cols = DB'(v.cols + 2); cfg_rows = DB'(v.rows + 1); cfg_pad = PB'(v.pad ^ 1);
      end
      case (v.vmode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (it % 2 == 0);
        default: bus.s_valid = 1'($urandom_range(0, 1));
      endcase
      case (v.rmode)
        0:       bus.fifo_s_ready = 1'b1;
        1:       bus.fifo_s_ready = !(it >= 12 && it <= 16);
        default: bus.fifo_s_ready = ($urandom_range(0, 3) != 0);
      endcase
      bus.s_data = (idx < total_in) ? src[idx] : rand_word();
      #1;
      if (!bus.fifo_s_ready) chk({nm, "/s_ready_gated"}, bus.s_ready, 0);
      if (idx >= total_in)   chk({nm, "/s_ready_after_last"}, bus.s_ready, 0);
      if (bus.s_valid && bus.s_ready) idx++;
      last_ready = bus.fifo_s_ready;
    end
    start = 1'b0;
    chk({nm, "/done_seen"}, done_it >= 0, 1);
    chk({nm, "/write_count"}, got.size(), exp_q.size());
    if (v.exp_writes >= 0) chk({nm, "/write_count_table"}, got.size(), v.exp_writes);
    chk({nm, "/inputs_accepted"}, idx, total_in);
    nbad = 0;
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      if (got[k] !== exp_q[k]) begin
        if (nbad == 0) $display("  %s first bad word %0d: got %h, expected %h", nm, k, got[k], exp_q[k]);
        nbad++;
      end
    chk({nm, "/word_order_errors"}, nbad, 0);
    if (v.exp_first >= 0) chk({nm, "/first_write_iter"}, first_w, v.exp_first);
    if (v.exp_done >= 0)  chk({nm, "/done_iter"}, done_it, v.exp_done);
    chk({nm, "/done_with_last_write"}, wr_at_done, exp_q.size() > 0);
    bus.s_valid = 1'b0;
    bus.fifo_s_ready = 1'b1;
    @(negedge clk);
    chk({nm, "/idle_busy"}, busy, 0);
    chk({nm, "/idle_done"}, done, 0);
    chk({nm, "/idle_wr_en"}, bus.fifo_wr_en, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          cols rows pad vm rm rstrt rstw  exp  first done
    vecs[0]  = '{3,  3,   1,  0, 0, -1,   -1,   25,  2,    26};
    names[0] = "3x3_p1";
    vecs[1]  = '{4,  2,   0,  0, 0, -1,   -1,   8,   2,    9};
    names[1] = "4x2_p0";
    vecs[2]  = '{3,  3,   1,  0, 1, -1,   -1,   25,  2,    31};
    names[2] = "3x3_p1_stall";
    vecs[3]  = '{2,  2,   2,  1, 0, -1,   -1,   36,  2,    -1};
    names[3] = "2x2_p2_toggle";
    vecs[4]  = '{3,  3,   1,  0, 0, 5,    -1,   25,  2,    26};
    names[4] = "restart_ignored";
    vecs[5]  = '{3,  3,   1,  0, 0, -1,   10,   -1,  -1,   -1};
    names[5] = "rst_at_write10";
    vecs[6]  = '{3,  3,   1,  0, 0, -1,   -1,   25,  2,    26};
    names[6] = "after_rst";
    vecs[7]  = '{0,  3,   1,  0, 0, -1,   -1,   0,   -1,   2};
    names[7] = "cols0_p1";
    vecs[8]  = '{2,  0,   0,  0, 0, -1,   -1,   0,   -1,   2};
    names[8] = "rows0_p0";
    vecs[9]  = '{1,  1,   3,  2, 2, -1,   -1,   49,  -1,   -1};
    names[9] = "1x1_p3_rand";
    vecs[10] = '{5,  1,   0,  2, 2, -1,   -1,   5,   -1,   -1};
    names[10] = "5x1_p0_rand";

    rst = 1'b1; start = 1'b0;
    cfg_cols = '0; cfg_rows = '0; cfg_pad = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.fifo_s_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/wr_en", bus.fifo_wr_en, 0);
    chk("reset/din_zero", bus.fifo_din == '0, 1);
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/s_ready", bus.s_ready, 0);

    for (int i = 0; i < NV; i++) run_frame(vecs[i], names[i]);

    for (int f = 0; f < 6; f++) begin
      vec_t r;
      r = '{int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
            2, 2, -1, -1, -1, -1, -1};
      run_frame(r, $sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/padding_gen.md
Name: padding_gen

Overview:
- Upstream neighbour of the padding FIFO stage in the TJPU feature path.
- Takes an unpadded feature-map stream (one WIDTH-bit channel-packed pixel word per beat, row-major).
- Inserts PAD zero words on every side and writes the padded map into the padding FIFO.
- Throttles writes with the FIFO's registered S_Ready almost-full flag.

Parameters:
- WIDTH, 256, pixel word width (matches the FIFO data width).
- DIM_BITS, 11, width of the row/column count fields.
- PAD_BITS, 2, width of the pad-size field (pad 0..3).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches config and begins a frame.
- cfg_cols  input  DIM_BITS  input columns per row.
- cfg_rows  input  DIM_BITS  input rows.
- cfg_pad  input  PAD_BITS  pad size P.
- s_data  input  WIDTH  input pixel word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block accepts s_data this cycle.
- fifo_din  output  WIDTH  word to the FIFO.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_s_ready  input  1  FIFO has room (its S_Ready).
- busy  output  1  frame in progress.
- done  output  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset values: fifo_wr_en=0, fifo_din=0, busy=0, done=0, FSM=IDLE, all counters 0. Reset mid-frame aborts immediately; no further writes; no done pulse.
- Padded dimensions: W = cols+2P, H = rows+2P, computed in DIM_BITS+1 bits with no overflow.
- Config: latched on start in IDLE. start while busy is ignored, and cfg_* changes mid-frame have no effect.
- Zero dimension: cols==0 or rows==0 -> zero writes; done pulses 2 cycles after start.
- FSM states:
  - IDLE: waits for start, then -> TOP (P>0) or LEFT.
  - TOP: emits P*W zero words, then -> LEFT.
  - LEFT: emits P zero words, then -> BODY (P=0 goes straight to BODY).
  - BODY: emits cols words from s_data, then -> RIGHT.
  - RIGHT: emits P zeros, then -> LEFT if more input rows remain, else BOTTOM (or FIN when P=0).
  - BOTTOM: emits P*W zeros, then -> FIN.
  - FIN: done=1 for exactly one cycle, then -> IDLE.
- Emission rule:
  - A zero word is emitted in a cycle when the state is TOP/LEFT/RIGHT/BOTTOM and fifo_s_ready=1.
  - A data word is emitted in BODY when s_valid && s_ready.
  - s_ready = (state==BODY) && fifo_s_ready. It is combinational and does not depend on s_valid.
- Latency: fifo_wr_en and fifo_din are registered, so an emit decided in cycle N appears on the FIFO port in cycle N+1. Zero words drive fifo_din=0. fifo_din holds its last value while fifo_wr_en=0.
- Backpressure: fifo_s_ready=0 stalls every state with no writes and no counter advance. Writes already in the register stage still complete (up to one word after deassert). The FIFO threshold absorbs this slack.
- Counters:
  - col_cnt counts 0..W-1 across each padded row.
  - row_cnt counts 0..H-1.
  - Both wrap to 0 at the row/frame end.
  - Total writes per frame are exactly W*H.
- busy: 1 from the cycle after an accepted start through the FIN cycle inclusive. It falls together with done deasserting.
- done timing: FIN is entered in the cycle after the last emit decision, so the done pulse coincides with the last fifo_wr_en=1 cycle.

Decomposition:
- Shared package tjpu_pkg holds:
  - FSM state enum pad_state_t (IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM, FIN).
  - DIM_BITS and PAD_BITS defaults.
  - A function padded_dim(dim, pad).
- One sub-module, pad_counter: a 2-D col/row counter with enable, terminal-value inputs and wrap flags. It is reused for the column and row sweep.
- The FSM and output register stay in padding_gen.

Test Plan:
- 3x3 map, P=1, s_valid always 1, fifo_s_ready=1 -> 25 writes in 25 consecutive cycles. The sequence is 6 zeros, d0..d2, 2 zeros, d3..d5, 2 zeros, d6..d8, 6 zeros. done coincides with write 25.
- 4x2 map, P=0 -> 8 writes, each exactly the input words in order, no zeros. s_ready is low after the 8th accept.
- 3x3, P=1, fifo_s_ready dropped for 5 cycles during the second data row -> s_ready=0 and no new emits during the drop. At most one trailing write occurs. Total is still 25 writes with the correct order.
- 2x2, P=2, s_valid toggling every other cycle -> 36 writes. Zero rows are unaffected by s_valid. Data words are written only on accepted beats.
- start re-pulsed mid-frame with different cfg -> ignored; the frame completes with the original W*H. rst asserted at write 10 -> no writes from the next cycle; busy=0, done never pulses; a new start afterwards runs a full clean frame.
- cfg_cols=0, P=1 -> zero writes, s_ready never high, done pulses 2 cycles after start.
